// File: rtl/song_selector_pkg.sv
// Shared definitions for the player front-end: state encoding, song-number width
// and default timing constants also used by the display and tone stages.
package song_selector_pkg;

    localparam int SONG_W                  = 4;
    localparam int NUM_SONGS_DEFAULT       = 3;
    localparam int DEBOUNCE_CYCLES_DEFAULT = 2_000_000;
    localparam int CNT_W_DEFAULT           = 21;

    localparam int NUM_BTNS = 3;
    localparam int BTN_NEXT = 0;
    localparam int BTN_PREV = 1;
    localparam int BTN_PLAY = 2;

    typedef enum logic {
        ST_BROWSE = 1'b0,
        ST_PLAY   = 1'b1
    } state_e;

endpackage

// File: rtl/song_selector_button_debounce.sv
// One pushbutton input path: two-flop synchroniser, stability-counter debounce and
// a single-cycle pulse on each accepted rising edge.
import song_selector_pkg::*;

module button_debounce #(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int CNT_W           = CNT_W_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic btn_level,
    output logic btn_press
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             level_q;
    logic             level_d;
    logic             level_prev_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            cnt_q        <= '0;
            level_q      <= 1'b0;
            level_prev_q <= 1'b0;
        end else begin
            sync1_q      <= btn_raw;
            sync2_q      <= sync1_q;
            cnt_q        <= cnt_d;
            level_q      <= level_d;
            level_prev_q <= level_q;
        end
    end

    // The counter only runs while the synced level disagrees with the accepted one,
    // so any return to the accepted level restarts the stability window.
    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        if (sync2_q == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            level_d = ~level_q;
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    assign btn_level = level_q;
    assign btn_press = level_q & ~level_prev_q;

endmodule

// File: rtl/song_selector.sv
// Player front-end: debounced next/prev/play buttons drive a browse/play FSM that
// selects a wrapping song number and issues play_start pulses.
import song_selector_pkg::*;

module song_selector #(
    parameter int NUM_SONGS       = NUM_SONGS_DEFAULT,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int CNT_W           = CNT_W_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              btn_next,
    input  logic              btn_prev,
    input  logic              btn_play,
    input  logic              song_done,
    output logic [SONG_W-1:0] num,
    output logic              playing,
    output logic              play_start
);

    localparam logic [SONG_W-1:0] LAST_SONG = SONG_W'(NUM_SONGS);
    localparam logic [SONG_W-1:0] FIRST_SONG = SONG_W'(1);

    logic [NUM_BTNS-1:0] btn_raw;
    logic [NUM_BTNS-1:0] btn_press;
    logic [NUM_BTNS-1:0] unused_btn_level;

    state_e            state_q;
    state_e            state_d;
    logic [SONG_W-1:0] num_q;
    logic [SONG_W-1:0] num_d;
    logic              play_start_q;
    logic              play_start_d;

    logic press_next;
    logic press_prev;
    logic press_play;

    function automatic logic [SONG_W-1:0] wrap_inc(input logic [SONG_W-1:0] n);
        return (n == LAST_SONG) ? FIRST_SONG : n + FIRST_SONG;
    endfunction

    function automatic logic [SONG_W-1:0] wrap_dec(input logic [SONG_W-1:0] n);
        return (n == FIRST_SONG) ? LAST_SONG : n - FIRST_SONG;
    endfunction

    assign btn_raw[BTN_NEXT] = btn_next;
    assign btn_raw[BTN_PREV] = btn_prev;
    assign btn_raw[BTN_PLAY] = btn_play;

    generate
        for (genvar gi = 0; gi < NUM_BTNS; gi++) begin : g_btn
            button_debounce #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
                .CNT_W          (CNT_W)
            ) u_debounce (
                .clk      (clk),
                .reset    (reset),
                .btn_raw  (btn_raw[gi]),
                .btn_level(unused_btn_level[gi]),
                .btn_press(btn_press[gi])
            );
        end
    endgenerate

    assign press_next = btn_press[BTN_NEXT];
    assign press_prev = btn_press[BTN_PREV];
    assign press_play = btn_press[BTN_PLAY];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_BROWSE;
            num_q        <= FIRST_SONG;
            play_start_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            num_q        <= num_d;
            play_start_q <= play_start_d;
        end
    end

    // Play/stop always takes priority over browsing and over auto-advance.
    always_comb begin
        state_d      = state_q;
        num_d        = num_q;
        play_start_d = 1'b0;
        case (state_q)
            ST_BROWSE: begin
                if (press_play) begin
                    state_d      = ST_PLAY;
                    play_start_d = 1'b1;
                end else if (press_next && !press_prev) begin
                    num_d = wrap_inc(num_q);
                end else if (press_prev && !press_next) begin
                    num_d = wrap_dec(num_q);
                end
            end
            ST_PLAY: begin
                if (press_play) begin
                    state_d = ST_BROWSE;
                end else if (song_done) begin
                    num_d        = wrap_inc(num_q);
                    play_start_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_BROWSE;
            end
        endcase
    end

    assign num        = num_q;
    assign playing    = (state_q == ST_PLAY);
    assign play_start = play_start_q;

endmodule
